// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache (8 x 4-byte blocks)
// with a three-state controller sequencing write-back and block fetch.
module dcache_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  valid, dirty;
  logic [2:0]  tags [8];
  logic [31:0] data [8];

  logic [2:0]  tag, idx;
  logic [1:0]  off;
  logic        req, hit, fill, store;
  logic [7:0]  sel_byte;

  assign tag = ADDRESS[7:5];
  assign idx = ADDRESS[4:2];
  assign off = ADDRESS[1:0];
  assign req = READ | WRITE;
  assign hit = valid[idx] & (tags[idx] == tag);

  assign sel_byte = data[idx][{off, 3'b000} +: 8];
  assign READDATA = (hit && !RESET) ? sel_byte : 8'h00;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nx;
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (store) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset; valid gates every use.
  always_ff @(posedge CLK) begin
    if (fill) begin
      data[idx] <= MEM_READDATA;
      tags[idx] <= tag;
    end else if (store) begin
      data[idx][{off, 3'b000} +: 8] <= WRITEDATA;
    end
  end

  always_comb begin
    state_nx      = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    fill          = 1'b0;
    store         = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            store = WRITE;
          end else begin
            BUSYWAIT = 1'b1;
            if (valid[idx] && dirty[idx])
              state_nx = WRITEBACK;
            else
              state_nx = FETCH;
          end
        end
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tags[idx], idx};
        MEM_WRITEDATA = data[idx];
        BUSYWAIT      = 1'b1;
        if (!MEM_BUSYWAIT)
          state_nx = FETCH;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag, idx};
        BUSYWAIT    = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Reset silences the CPU and memory sides at once.
    if (RESET) begin
      BUSYWAIT  = 1'b0;
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      fill      = 1'b0;
      store     = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: hit vectors from a table plus
// hand-written miss, eviction and reset sequences against a 5-cycle memory.
module tb_dcache_controller;

  localparam int LAT = 5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [64];
  int          cnt;

  dcache_controller dut (
    .CLK(CLK),
    .RESET(RESET),
    .READ(READ),
    .WRITE(WRITE),
    .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA),
    .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory: busy for LAT cycles of a request, completes on the next one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cnt <= 0;
    else if (MEM_READ || MEM_WRITE) cnt <= (cnt == LAT) ? 0 : cnt + 1;
  end

  always_comb begin
    MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt != LAT);
    MEM_READDATA = mem[MEM_ADDRESS];
  end

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       mr;
    logic       mw;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] rexp, input int nbusy,
                        input logic ewb, input logic [5:0] wba,
                        input logic [31:0] wbd, input logic efe,
                        input logic [5:0] fea);
    int          n;
    logic        wbs, fes, ovl, ord;
    logic [5:0]  wa, fa;
    logic [31:0] wdd;
    n = 0; wbs = 0; fes = 0; ovl = 0; ord = 0;
    wa = '0; fa = '0; wdd = '0;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    while (n <= 60) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      n++;
      if (MEM_READ && MEM_WRITE) ovl = 1;
      if (MEM_WRITE && !wbs) begin
        wbs = 1; wa = MEM_ADDRESS; wdd = MEM_WRITEDATA;
        if (fes) ord = 1;
      end
      if (MEM_READ && !fes) begin
        fes = 1; fa = MEM_ADDRESS;
      end
    end
    chk("busy_cycles", n, nbusy);
    chk("wb_seen", 32'(wbs), 32'(ewb));
    if (ewb) begin
      chk("wb_addr", 32'(wa), 32'(wba));
      chk("wb_data", wdd, wbd);
    end
    chk("fetch_seen", 32'(fes), 32'(efe));
    if (efe) chk("fetch_addr", 32'(fa), 32'(fea));
    chk("mem_overlap", 32'(ovl), 32'd0);
    chk("wb_before_fetch", 32'(ord), 32'd0);
    chk("rdata", 32'(READDATA), 32'(rexp));
    @(posedge CLK); #1;
    READ = 0; WRITE = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {24'h0, 2'b00, i[5:0]};
    mem[0]  = 32'h44332211;
    mem[1]  = 32'h0D0C0B0A;
    mem[8]  = 32'hDDCCBBAA;
    mem[9]  = 32'h19181716;
    mem[16] = 32'h332211C3;

    vecs[0] = '{1'b1, 1'b0, 8'h03, 8'h00, 8'h44, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h02, 8'hAB, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'hAB, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

    RESET = 1; READ = 1; WRITE = 0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_readdata", 32'(READDATA), 32'd0);
    @(negedge CLK);
    RESET = 0; READ = 0;

    // Cold read miss: 1 + L + 1 busy cycles.
    access(1, 0, 8'h00, 8'h00, 8'h11, 7, 0, 6'h0, 32'h0, 1, 6'h00);

    foreach (vecs[i]) begin
      @(posedge CLK); #1;
      READ = vecs[i].rd; WRITE = vecs[i].wr;
      ADDRESS = vecs[i].addr; WRITEDATA = vecs[i].wdata;
      @(negedge CLK);
      chk($sformatf("v%0d_busy", i), 32'(BUSYWAIT), 32'(vecs[i].busy));
      chk($sformatf("v%0d_rdata", i), 32'(READDATA), 32'(vecs[i].rdata));
      chk($sformatf("v%0d_mrd", i), 32'(MEM_READ), 32'(vecs[i].mr));
      chk($sformatf("v%0d_mwr", i), 32'(MEM_WRITE), 32'(vecs[i].mw));
    end

    // Dirty eviction of block 0 by tag 1.
    access(1, 0, 8'h20, 8'h00, 8'hAA, 13,
           1, 6'h00, 32'h44AB2211, 1, 6'h08);

    // Write miss to clean block 1: fetch only, old byte visible on hit.
    access(0, 1, 8'h05, 8'h55, 8'h0B, 7, 0, 6'h0, 32'h0, 1, 6'h01);
    access(1, 0, 8'h05, 8'h00, 8'h55, 0, 0, 6'h0, 32'h0, 0, 6'h0);

    // Evicting block 1 proves the store merged and set dirty.
    access(1, 0, 8'h25, 8'h00, 8'h17, 13,
           1, 6'h01, 32'h0D0C550A, 1, 6'h09);

    // READ and WRITE together on a hit: a store, no memory traffic.
    access(1, 1, 8'h24, 8'h99, 8'h16, 0, 0, 6'h0, 32'h0, 0, 6'h0);
    access(1, 0, 8'h24, 8'h00, 8'h99, 0, 0, 6'h0, 32'h0, 0, 6'h0);

    // Reset in the middle of a fetch.
    @(posedge CLK); #1;
    READ = 1; ADDRESS = 8'h40;
    repeat (3) @(negedge CLK);
    chk("mid_fetch_mem_read", 32'(MEM_READ), 32'd1);
    chk("mid_fetch_addr", 32'(MEM_ADDRESS), 32'h10);
    #2 RESET = 1;
    #1;
    chk("async_rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("async_rst_busywait", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    RESET = 0; READ = 0;

    // Valid was cleared, so the same address misses again.
    access(1, 0, 8'h40, 8'h00, 8'hC3, 7, 0, 6'h0, 32'h0, 1, 6'h10);
    access(1, 0, 8'h24, 8'h00, 8'h16, 7, 0, 6'h0, 32'h0, 1, 6'h09);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
